// File: rtl/serial_mag_comp_pkg.sv
// rtl/serial_mag_comp_pkg.sv - shared types and helpers for the bit-serial magnitude comparator
package serial_mag_comp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REL_EQ = 2'd0,
      REL_LT = 2'd1,
      REL_GT = 2'd2
   } rel_t;

   // Map the running relation onto the {L,G,E} flag triple; always exactly one-hot.
   function automatic logic [2:0] rel_to_lge(input rel_t rel);
      case (rel)
         REL_LT:  return 3'b100;
         REL_GT:  return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

endpackage

// File: rtl/serial_mag_comp_bit_rel_step.sv
// rtl/serial_mag_comp_bit_rel_step.sv - per-bit relation update; SERIAL_MAG_COMP_MSB_FIRST_EN selects bit order
module bit_rel_step
   import serial_mag_comp_pkg::*;
(
   input  logic a_bit,
   input  logic b_bit,
   input  rel_t rel_in,
   output rel_t rel_out
);

   // Fold one bit pair into the relation accumulated so far.
   always_comb begin
      rel_out = rel_in;
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
      // Most-significant bits come first, so the first differing pair is final.
      if (rel_in == REL_EQ && a_bit != b_bit) begin
         rel_out = a_bit ? REL_GT : REL_LT;
      end
`else
      // Least-significant bits come first, so every later differing pair overrides.
      if (a_bit != b_bit) begin
         rel_out = a_bit ? REL_GT : REL_LT;
      end
`endif
   end

endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial magnitude comparator top; option macro SERIAL_MAG_COMP_MSB_FIRST_EN
module serial_mag_comp
   import serial_mag_comp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic rst,
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
   output logic early_decide,
`endif
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic L,
   output logic G,
   output logic E,
   output logic result_valid
);

   state_t           state;
   rel_t             rel;
   rel_t             rel_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [2:0]       lge_next;

   assign cnt_inc  = cnt + CNT_W'(1);
   assign lge_next = rel_to_lge(rel_next);

   bit_rel_step u_step (
      .a_bit   (a_bit),
      .b_bit   (b_bit),
      .rel_in  (rel),
      .rel_out (rel_next)
   );

   // Control FSM: consumes bit pairs in RUN, publishes the flags on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rel          <= REL_EQ;
         cnt          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         L            <= 1'b0;
         G            <= 1'b0;
         E            <= 1'b0;
         result_valid <= 1'b0;
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
         early_decide <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
         early_decide <= 1'b0;
`endif
         case (state)
            // DONE behaves like IDLE for start; done is already high this cycle.
            IDLE, DONE: begin
               if (start) begin
                  state        <= RUN;
                  busy         <= 1'b1;
                  rel          <= REL_EQ;
                  cnt          <= '0;
                  result_valid <= 1'b0;
                  {L, G, E}    <= 3'b000;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (start) begin
                  // Abort and restart; any bit offered alongside start is dropped.
                  rel <= REL_EQ;
                  cnt <= '0;
               end else if (bit_valid) begin
                  rel <= rel_next;
                  cnt <= cnt_inc;
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
                  if (rel == REL_EQ && rel_next != REL_EQ) begin
                     early_decide <= 1'b1;
                  end
`endif
                  if (cnt_inc == CNT_W'(WIDTH)) begin
                     state        <= DONE;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     result_valid <= 1'b1;
                     {L, G, E}    <= lge_next;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - self-checking bench for serial_mag_comp; honours SERIAL_MAG_COMP_MSB_FIRST_EN
module tb_serial_mag_comp;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic bit_valid;
   logic a_bit;
   logic b_bit;
   logic busy;
   logic done;
   logic L;
   logic G;
   logic E;
   logic result_valid;
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
   logic early_decide;
`endif

   int checks = 0;
   int errors = 0;

   logic [2:0] exp_q[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] stall;
      logic [2:0] lge;
   } vec_t;

   vec_t vecs[8];

   serial_mag_comp #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
      .early_decide (early_decide),
`endif
      .start        (start),
      .bit_valid    (bit_valid),
      .a_bit        (a_bit),
      .b_bit        (b_bit),
      .busy         (busy),
      .done         (done),
      .L            (L),
      .G            (G),
      .E            (E),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx(input int i);
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
      return W - 1 - i;
`else
      return i;
`endif
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check("result_lge", {29'd0, L, G, E}, {29'd0, e});
            check("result_valid_on_done", {31'd0, result_valid}, 32'd1);
         end
      end
   end

   // Full comparison: start edge, W beats with optional stall cycles, ends in the done cycle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] stall,
                         input logic [2:0] lge, input logic valid_on_start);
      int pulses = 0;
      int pulse_beat = 0;
      int exp_beat = 0;
      start     = 1'b1;
      bit_valid = valid_on_start;
      a_bit     = 1'b1;
      b_bit     = 1'b0;
      exp_q.push_back(lge);
      tick();
      start     = 1'b0;
      bit_valid = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_clear", {27'd0, result_valid, L, G, E, done}, 32'd0);
      for (int i = 0; i < W; i++) begin
         if (stall[i]) begin
            bit_valid = 1'b0;
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
            check("stall_flags", {30'd0, busy, done}, 32'd2);
         end
         bit_valid = 1'b1;
         a_bit     = a[idx(i)];
         b_bit     = b[idx(i)];
         tick();
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
         if (early_decide) begin
            pulses++;
            pulse_beat = i + 1;
         end
`endif
         if (i < W - 1) check("run_flags", {30'd0, busy, done}, 32'd2);
      end
      bit_valid = 1'b0;
      check("done_latency", {30'd0, busy, done}, 32'd1);
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
      for (int i = 0; i < W; i++) begin
         if (exp_beat == 0 && a[W-1-i] != b[W-1-i]) exp_beat = i + 1;
      end
      check("early_count", pulses, (exp_beat != 0) ? 32'd1 : 32'd0);
      if (exp_beat != 0) check("early_beat", pulse_beat, exp_beat);
`else
      check("no_early", pulses + pulse_beat + exp_beat, 32'd0);
`endif
   endtask

   // After the done cycle: back in IDLE with the result held for two cycles.
   task automatic check_hold(input logic [2:0] lge);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("hold", {26'd0, busy, done, result_valid, L, G, E}, {26'd0, 3'b001, lge});
      end
   endtask

   // Start and feed n beats without queuing a result; used before aborts.
   task automatic partial(input logic [7:0] a, input logic [7:0] b, input int n);
      start     = 1'b1;
      bit_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         bit_valid = 1'b1;
         a_bit     = a[idx(i)];
         b_bit     = b[idx(i)];
         tick();
         check("partial_flags", {30'd0, busy, done}, 32'd2);
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{a: 8'h5A, b: 8'h5A, stall: 8'h00, lge: 3'b001};
      vecs[1] = '{a: 8'h80, b: 8'h7F, stall: 8'h00, lge: 3'b010};
      vecs[2] = '{a: 8'h01, b: 8'h02, stall: 8'h00, lge: 3'b100};
      vecs[3] = '{a: 8'hF0, b: 8'h0F, stall: 8'h32, lge: 3'b010};
      vecs[4] = '{a: 8'hC3, b: 8'hA3, stall: 8'h00, lge: 3'b010};
      vecs[5] = '{a: 8'h00, b: 8'hFF, stall: 8'h00, lge: 3'b100};
      vecs[6] = '{a: 8'hFF, b: 8'hFF, stall: 8'h81, lge: 3'b001};
      vecs[7] = '{a: 8'h7F, b: 8'h80, stall: 8'h00, lge: 3'b100};

      rst       = 1'b1;
      start     = 1'b1;
      bit_valid = 1'b1;
      a_bit     = 1'b1;
      b_bit     = 1'b0;
      tick();
      tick();
      check("reset_outputs", {26'd0, busy, done, result_valid, L, G, E}, 32'd0);
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
      check("reset_early", {31'd0, early_decide}, 32'd0);
`endif
      rst       = 1'b0;
      start     = 1'b0;
      bit_valid = 1'b0;
      tick();
      check("idle_outputs", {26'd0, busy, done, result_valid, L, G, E}, 32'd0);

      for (int v = 0; v < 8; v++) begin
         run_op(vecs[v].a, vecs[v].b, vecs[v].stall, vecs[v].lge, 1'b0);
         check_hold(vecs[v].lge);
      end

      // Restart mid-run with a bit offered alongside start: that bit must be dropped.
      partial(8'hFF, 8'h00, 4);
      run_op(8'h10, 8'h20, 8'h00, 3'b100, 1'b1);
      check_hold(3'b100);

      // Reset mid-run discards everything; the following start ignores its bit_valid.
      partial(8'hF0, 8'h0F, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_reset", {26'd0, busy, done, result_valid, L, G, E}, 32'd0);
`ifdef SERIAL_MAG_COMP_MSB_FIRST_EN
      check("midrun_reset_early", {31'd0, early_decide}, 32'd0);
`endif
      run_op(8'h33, 8'h34, 8'h00, 3'b100, 1'b1);
      check_hold(3'b100);

      // Start during the done cycle chains straight into the next comparison.
      run_op(8'hA5, 8'h5A, 8'h00, 3'b010, 1'b0);
      run_op(8'h3C, 8'h3C, 8'h12, 3'b001, 1'b0);
      check_hold(3'b001);

      repeat (3) tick();
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Bit-serial magnitude comparator for two WIDTH-bit operands streamed one bit pair per accepted beat, LSB-first by default.
- Sequential counterpart of the team's parallel 1-bit comparator cell. It lets narrow serial links (shift-register outputs, UART-fed operands) be compared without deserialising.
- Produces registered L/G/E flags and a one-cycle done pulse after WIDTH bits.

Parameters:
- WIDTH, 8, operand length in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin new comparison; clears accumulated relation.
- bit_valid  input  1  a_bit/b_bit valid this cycle.
- a_bit  input  1  serial operand A bit.
- b_bit  input  1  serial operand B bit.
- busy  output  1  high while in RUN (accepting bits).
- done  output  1  one-cycle pulse: result just became valid.
- L  output  1  A < B (valid when result_valid).
- G  output  1  A > B.
- E  output  1  A == B.
- result_valid  output  1  L/G/E hold a completed result.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - busy=0, done=0, L=0, G=0, E=0, result_valid=0, counter=0.
  - Reset wins over every other input, including reset asserted mid-RUN; the partial comparison is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 moves to RUN next cycle. Internal relation is initialised to EQ and the counter to 0.
  - result_valid drops to 0 on the start edge; L/G/E are cleared at the same time.
  - bit_valid is ignored in IDLE, including in the same cycle as start.
- RUN (busy=1):
  - Each cycle with bit_valid=1 consumes one bit pair and increments the counter.
  - LSB-first rule: a_bit>b_bit sets rel=GT; a_bit<b_bit sets rel=LT; equal bits keep rel. The later, more-significant bit overrides.
  - bit_valid=0 means a stall: state, counter and rel are held. There is no timeout.
  - When the WIDTH-th bit is consumed, go to DONE next cycle.
- DONE (one cycle):
  - done=1, result_valid=1.
  - L/G/E are registered from rel, exactly one-hot.
  - Return to IDLE next cycle.
  - L/G/E and result_valid hold until the next start or rst.
- start in RUN: aborts and restarts. Counter goes to 0, rel to EQ, no done pulse, busy stays 1.
  - If bit_valid is high in that same cycle, the bit is dropped.
- start in DONE: honoured. done still pulses this cycle, then the block enters RUN with cleared state instead of IDLE.
- Latency: done asserts the cycle after the edge that consumed the last bit. A back-to-back stream of WIDTH beats gives done at cycle WIDTH+1 after the start edge.
- Counter compares against WIDTH exactly; it never wraps.

Optional Feature:
- Macro: SERIAL_MAG_COMP_MSB_FIRST_EN.
- Defined: bits arrive MSB-first.
  - The first unequal bit pair fixes rel; later bits are don't-care for the result.
  - Remaining beats are still consumed until the counter reaches WIDTH, so the done timing is unchanged.
  - An extra output port, early_decide (1 bit), pulses one cycle when rel first leaves EQ. It resets to 0.
- Undefined: LSB-first override rule as above; the early_decide port does not exist.

Decomposition:
- Package serial_mag_comp_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - relation enum (REL_EQ, REL_LT, REL_GT, 2-bit);
  - function rel_to_lge() returning a 3-bit {L,G,E}.
- Sub-module bit_rel_step (combinational): inputs a_bit, b_bit, rel_in; output rel_out.
  - It implements the per-bit update rule.
  - Its ordering is selected by the same macro.

Test Plan (WIDTH=8, LSB-first unless noted):
- Equality: start, stream A=0x5A and B=0x5A over 8 consecutive beats -> done at cycle 9, E=1, L=0, G=0, result_valid=1.
- MSB override: A=0x80, B=0x7F -> lower bits favour B but bit7 decides, so G=1. Then A=0x01, B=0x02 -> L=1.
- Stalls: A=0xF0, B=0x0F with bit_valid low on beats 2, 5 and 6 -> busy is held, the counter freezes, done arrives 3 cycles later than unstalled, G=1.
- Restart: after 4 beats of A=0xFF, B=0x00, assert start with bit_valid=1 -> no done, that bit is dropped. Stream A=0x10, B=0x20 -> L=1, single done pulse.
- Reset mid-RUN: rst after 3 beats -> next cycle all outputs are 0 and state is IDLE. A start with bit_valid in the same cycle consumes no bit.
- MSB_FIRST_EN build: A=0xC3, B=0xA3 MSB-first -> early_decide pulses on beat 2, G=1. done is still at cycle 9, and only one early_decide pulse occurs.
